fifo_sync: RTL and testbench
============================

Name: fifo_sync

Overview:
- Single-clock synchronous FIFO, the storage stage on either side of the pop-to-push bridge.
- Push side: data_push, push, full. Pop side: pop, data_pop, valid, empty.
- Reads are registered. A pop accepted in cycle t returns the head word on data_pop with valid=1 in cycle t+1.
- Register-array storage, power-of-two depth, exact occupancy count.

Parameters:
- WIDTH, 32: data word width in bits.
- DEPTH, 8: number of entries. Power of two, minimum 2.
- AW, $clog2(DEPTH): pointer width. Derived; do not override.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- data_push  input  WIDTH  write data, sampled when push is accepted.
- push  input  1  write request.
- full  output  1  high when count == DEPTH.
- data_pop  output  WIDTH  read data, meaningful only while valid=1.
- valid  output  1  data_pop carries the word popped in the previous cycle.
- empty  output  1  high when count == 0.
- pop  input  1  read request.
- count  output  AW+1  current occupancy, 0..DEPTH.

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high.
- Reset values, applied at the rising edge with rst=1:
  - wr_ptr=0, rd_ptr=0, count=0.
  - empty=1, full=0, valid=0, data_pop=0.
  - Storage contents are not cleared.
- Reset mid-operation: in-flight data is discarded. A pop accepted in the cycle before reset does not produce valid in the reset cycle. push and pop are ignored while rst=1.
- Accepted push: push_ok = push && !full, evaluated on current-cycle flags. When push_ok, mem[wr_ptr] <= data_push and wr_ptr increments.
- Accepted pop: pop_ok = pop && !empty. When pop_ok, data_pop <= mem[rd_ptr] and rd_ptr increments.
- valid: next valid = pop_ok. Single-cycle pulse per accepted pop; back-to-back pops give continuous valid.
- data_pop when valid=0: holds its last value.
- Rejected requests: push while full and pop while empty are dropped silently. No state change.
- Count: count <= count + push_ok - pop_ok. full and empty are registered and derived from next count, so they are valid in the same cycle as count.
- Simultaneous push and pop:
  - Neither full nor empty: both accepted, count unchanged.
  - Full: pop accepted, push rejected (full is checked before the pop takes effect). Count becomes DEPTH-1.
  - Empty: push accepted, pop rejected. No same-cycle write-through; the word becomes readable the next cycle.
- Wrap-around: pointers are AW bits and wrap modulo DEPTH naturally.
- Read/write collision: a read of an entry never collides with a write to the same entry in the same cycle, because pop_ok requires count>0 and push_ok requires count<DEPTH.
- Latency: push to first possible pop is 1 cycle (empty deasserts the cycle after push_ok). pop to valid is 1 cycle.
- Downstream backpressure: the consumer must hold pop low once it cannot take one more word. valid is never stalled and there is no skid buffer.

Optional Feature:
- Macro: FIFO_ERR_FLAG_EN.
- When defined, adds two outputs:
  - overflow, output, 1 bit: set on push && full.
  - underflow, output, 1 bit: set on pop && empty.
  - Both are sticky; they clear only on rst and reset to 0.
  - Setting them does not alter FIFO state.
- When undefined, both ports and their logic are absent, and all other behaviour is identical.

Test Plan (DEPTH=4, WIDTH=32):
- Reset, then idle 3 cycles -> empty=1, full=0, count=0, valid=0, data_pop=0.
- Push 0xA0,0xA1,0xA2,0xA3 on consecutive cycles -> count steps 1..4. full=1 the cycle after the 4th push. A 5th push of 0xFF is dropped: count stays 4, overflow=1 if FIFO_ERR_FLAG_EN.
- From full, pop 4 consecutive cycles -> valid=1 on cycles t+1..t+4 with data_pop 0xA0,0xA1,0xA2,0xA3. empty=1 after the last pop. A further pop gives valid=0 next cycle and underflow=1 if FIFO_ERR_FLAG_EN.
- Simultaneous push+pop while full, then while empty:
  - While full: count goes 4 -> 3, data_pop is the old head, the pushed word is not stored.
  - While empty: count goes 0 -> 1, valid=0 next cycle, the word pops correctly afterwards.
- Wrap-around: push 10 words 0x10..0x19 interleaved with pops, keeping count ≤ 3 -> data_pop sequence equals the push order exactly across pointer wrap.
- Assert rst the cycle after an accepted pop with count=2 -> valid=0 in the following cycle, count=0, empty=1. A subsequent push of 0x55 then pop returns 0x55.

Source files
------------

// File: rtl/fifo_sync.sv
// Single-clock synchronous FIFO with registered read port and exact occupancy count.
// Optional sticky overflow/underflow flags are built when FIFO_ERR_FLAG_EN is defined.
module fifo_sync #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_push,
    input  logic             push,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] data_pop,
    output logic             valid,
    output logic             empty,
    output logic [AW:0]      count
`ifdef FIFO_ERR_FLAG_EN
    ,
    output logic             overflow,
    output logic             underflow
`endif
);

    localparam logic [AW:0]   DEPTH_C  = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1'b1);
    localparam logic [AW:0]   CNT_ZERO = {(AW+1){1'b0}};
    localparam logic [AW-1:0] PTR_ONE  = AW'(1'b1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic [AW:0]      count_nxt_s;
    logic             full_r;
    logic             empty_r;
    logic             valid_r;
    logic [WIDTH-1:0] data_pop_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    // Request qualification and next occupancy; flags are checked before either side takes effect.
    always_comb begin
        push_ok_s   = push && !full_r;
        pop_ok_s    = pop && !empty_r;
        count_nxt_s = count_r;
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE;
            2'b01:   count_nxt_s = count_r - CNT_ONE;
            default: count_nxt_s = count_r;
        endcase
    end

    // Storage array write; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (!rst && push_ok_s) begin
            mem_r[wr_ptr_r] <= data_push;
        end
    end

    // Pointers, occupancy, flags and the registered read port.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            count_r    <= CNT_ZERO;
            full_r     <= 1'b0;
            empty_r    <= 1'b1;
            valid_r    <= 1'b0;
            data_pop_r <= {WIDTH{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            // A read never targets the slot being written: pop needs count>0, push needs count<DEPTH.
            if (pop_ok_s) begin
                rd_ptr_r   <= rd_ptr_r + PTR_ONE;
                data_pop_r <= mem_r[rd_ptr_r];
            end
            valid_r <= pop_ok_s;
            count_r <= count_nxt_s;
            full_r  <= (count_nxt_s == DEPTH_C);
            empty_r <= (count_nxt_s == CNT_ZERO);
        end
    end

    assign full     = full_r;
    assign empty    = empty_r;
    assign valid    = valid_r;
    assign data_pop = data_pop_r;
    assign count    = count_r;

`ifdef FIFO_ERR_FLAG_EN
    logic overflow_r;
    logic underflow_r;

    // Sticky error flags; they observe rejected requests but never influence FIFO state.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            if (push && full_r) begin
                overflow_r <= 1'b1;
            end
            if (pop && empty_r) begin
                underflow_r <= 1'b1;
            end
        end
    end

    assign overflow  = overflow_r;
    assign underflow = underflow_r;
`endif

endmodule

// File: tb/tb_fifo_sync.sv
// Randomised and directed bench for fifo_sync (DEPTH=4, WIDTH=32) against a queue-based model.
module tb_fifo_sync;

    logic        clk;
    logic        rst;
    logic [31:0] data_push;
    logic        push;
    logic        pop;
    logic        full;
    logic [31:0] data_pop;
    logic        valid;
    logic        empty;
    logic [2:0]  count;
`ifdef FIFO_ERR_FLAG_EN
    logic        overflow;
    logic        underflow;
`endif

    int total;
    int bad;

    // Behavioural model: contents as a queue, plus read-port and flag state.
    logic [31:0] q[$];
    bit          m_valid;
    logic [31:0] m_data;
    bit          m_ovf;
    bit          m_unf;

    fifo_sync #(.WIDTH(32), .DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .data_push (data_push),
        .push      (push),
        .full      (full),
        .pop       (pop),
        .data_pop  (data_pop),
        .valid     (valid),
        .empty     (empty),
        .count     (count)
`ifdef FIFO_ERR_FLAG_EN
        ,
        .overflow  (overflow),
        .underflow (underflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [37:0] exp_vec();
        return {3'(q.size()), q.size() == 4, q.size() == 0, m_valid, m_data};
    endfunction

    // One clock: drive at negedge, advance the model at posedge, return #1 later for sampling.
    task automatic step(input bit r, input bit p, input bit pp, input logic [31:0] d);
        bit was_full;
        bit was_empty;
        @(negedge clk);
        rst = r; push = p; pop = pp; data_push = d;
        @(posedge clk);
        if (r) begin
            q.delete();
            m_valid = 1'b0; m_data = 32'h0; m_ovf = 1'b0; m_unf = 1'b0;
        end else begin
            was_full  = (q.size() == 4);
            was_empty = (q.size() == 0);
            m_valid   = pp && !was_empty;
            if (m_valid) m_data = q.pop_front();
            if (p && !was_full) q.push_back(d);
            if (p && was_full) m_ovf = 1'b1;
            if (pp && was_empty) m_unf = 1'b1;
        end
        #1;
        rst = 1'b0; push = 1'b0; pop = 1'b0;
    endtask

    task automatic test_reset();
        step(1'b1, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0, 32'h0);
            total++;
            if ({count, full, empty, valid, data_pop} !== {3'd0, 1'b0, 1'b1, 1'b0, 32'h0}) begin
                bad++;
                $display("FAIL reset_idle%0d: got cnt=%0d f=%b e=%b v=%b d=%h, want cnt=0 f=0 e=1 v=0 d=0",
                         i, count, full, empty, valid, data_pop);
            end
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 1'b0, 32'hA0 + 32'(i));
            total++;
            if (count !== 3'(i + 1) || {count, full, empty, valid, data_pop} !== exp_vec()) begin
                bad++;
                $display("FAIL fill%0d: got cnt=%0d f=%b e=%b, want cnt=%0d vec=%h",
                         i, count, full, empty, i + 1, exp_vec());
            end
        end
        total++;
        if (full !== 1'b1) begin
            bad++;
            $display("FAIL fill_full: got full=%b, want 1", full);
        end
        step(1'b0, 1'b1, 1'b0, 32'hFF);
        total++;
        if (count !== 3'd4 || full !== 1'b1) begin
            bad++;
            $display("FAIL push_when_full: got cnt=%0d f=%b, want cnt=4 f=1", count, full);
        end
`ifdef FIFO_ERR_FLAG_EN
        total++;
        if (overflow !== 1'b1 || underflow !== 1'b0) begin
            bad++;
            $display("FAIL overflow_flag: got ovf=%b unf=%b, want ovf=1 unf=0", overflow, underflow);
        end
`endif
    endtask

    task automatic test_drain();
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 1'b1, 32'h0);
            total++;
            if (valid !== 1'b1 || data_pop !== 32'hA0 + 32'(i) ||
                {count, full, empty, valid, data_pop} !== exp_vec()) begin
                bad++;
                $display("FAIL drain%0d: got v=%b d=%h cnt=%0d, want v=1 d=%h cnt=%0d",
                         i, valid, data_pop, count, 32'hA0 + 32'(i), 3 - i);
            end
        end
        total++;
        if (empty !== 1'b1) begin
            bad++;
            $display("FAIL drain_empty: got empty=%b, want 1", empty);
        end
        step(1'b0, 1'b0, 1'b1, 32'h0);
        total++;
        if (valid !== 1'b0 || count !== 3'd0 || data_pop !== 32'hA3) begin
            bad++;
            $display("FAIL pop_when_empty: got v=%b cnt=%0d d=%h, want v=0 cnt=0 d=a3", valid, count, data_pop);
        end
`ifdef FIFO_ERR_FLAG_EN
        total++;
        if (underflow !== 1'b1 || overflow !== 1'b1) begin
            bad++;
            $display("FAIL underflow_flag: got unf=%b ovf=%b, want 1 1", underflow, overflow);
        end
`endif
    endtask

    task automatic test_simultaneous();
        logic [31:0] words [4];
        for (int i = 0; i < 4; i++) begin
            words[i] = $urandom;
            step(1'b0, 1'b1, 1'b0, words[i]);
        end
        step(1'b0, 1'b1, 1'b1, 32'hEE);
        total++;
        if (count !== 3'd3 || valid !== 1'b1 || data_pop !== words[0] || full !== 1'b0) begin
            bad++;
            $display("FAIL pushpop_full: got cnt=%0d v=%b d=%h f=%b, want cnt=3 v=1 d=%h f=0",
                     count, valid, data_pop, full, words[0]);
        end
        for (int i = 1; i < 4; i++) begin
            step(1'b0, 1'b0, 1'b1, 32'h0);
            total++;
            if (data_pop !== words[i] || {count, full, empty, valid, data_pop} !== exp_vec()) begin
                bad++;
                $display("FAIL pushpop_full_drain%0d: got d=%h cnt=%0d, want d=%h", i, data_pop, count, words[i]);
            end
        end
        step(1'b0, 1'b1, 1'b1, 32'h77);
        total++;
        if (count !== 3'd1 || valid !== 1'b0 || empty !== 1'b0) begin
            bad++;
            $display("FAIL pushpop_empty: got cnt=%0d v=%b e=%b, want cnt=1 v=0 e=0", count, valid, empty);
        end
        step(1'b0, 1'b0, 1'b1, 32'h0);
        total++;
        if (valid !== 1'b1 || data_pop !== 32'h77 || count !== 3'd0) begin
            bad++;
            $display("FAIL pushpop_empty_read: got v=%b d=%h cnt=%0d, want v=1 d=77 cnt=0", valid, data_pop, count);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] nxt;
        nxt = 32'h10;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1, q.size() >= 2, 32'h10 + 32'(i));
            if (valid) begin
                total++;
                if (data_pop !== nxt || count > 3'd3) begin
                    bad++;
                    $display("FAIL wrap%0d: got d=%h cnt=%0d, want d=%h cnt<=3", i, data_pop, count, nxt);
                end
                nxt = nxt + 32'h1;
            end
        end
        for (int i = 0; i < 4 && q.size() > 0; i++) begin
            step(1'b0, 1'b0, 1'b1, 32'h0);
            total++;
            if (valid !== 1'b1 || data_pop !== nxt) begin
                bad++;
                $display("FAIL wrap_drain%0d: got v=%b d=%h, want v=1 d=%h", i, valid, data_pop, nxt);
            end
            nxt = nxt + 32'h1;
        end
        total++;
        if (nxt !== 32'h1A || empty !== 1'b1) begin
            bad++;
            $display("FAIL wrap_total: got next=%h e=%b, want next=1a e=1", nxt, empty);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 32'h31 + 32'(i));
        step(1'b0, 1'b0, 1'b1, 32'h0);
        total++;
        if (count !== 3'd2 || valid !== 1'b1 || data_pop !== 32'h31) begin
            bad++;
            $display("FAIL midrst_pre: got cnt=%0d v=%b d=%h, want cnt=2 v=1 d=31", count, valid, data_pop);
        end
        step(1'b1, 1'b1, 1'b1, 32'hDEAD);
        total++;
        if ({count, full, empty, valid, data_pop} !== {3'd0, 1'b0, 1'b1, 1'b0, 32'h0}) begin
            bad++;
            $display("FAIL midrst: got cnt=%0d f=%b e=%b v=%b d=%h, want cnt=0 f=0 e=1 v=0 d=0",
                     count, full, empty, valid, data_pop);
        end
`ifdef FIFO_ERR_FLAG_EN
        total++;
        if (overflow !== 1'b0 || underflow !== 1'b0) begin
            bad++;
            $display("FAIL midrst_flags: got ovf=%b unf=%b, want 0 0", overflow, underflow);
        end
`endif
        step(1'b0, 1'b1, 1'b0, 32'h55);
        step(1'b0, 1'b0, 1'b1, 32'h0);
        total++;
        if (valid !== 1'b1 || data_pop !== 32'h55 || empty !== 1'b1) begin
            bad++;
            $display("FAIL midrst_after: got v=%b d=%h e=%b, want v=1 d=55 e=1", valid, data_pop, empty);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 63) == 0, $urandom_range(0, 99) < 55,
                 $urandom_range(0, 99) < 50, $urandom);
            total++;
            if ({count, full, empty, valid, data_pop} !== exp_vec()) begin
                bad++;
                $display("FAIL random%0d: got cnt=%0d f=%b e=%b v=%b d=%h, want vec=%h",
                         i, count, full, empty, valid, data_pop, exp_vec());
            end
`ifdef FIFO_ERR_FLAG_EN
            total++;
            if ({overflow, underflow} !== {m_ovf, m_unf}) begin
                bad++;
                $display("FAIL random_flags%0d: got ovf=%b unf=%b, want %b %b",
                         i, overflow, underflow, m_ovf, m_unf);
            end
`endif
        end
    endtask

    initial begin
        total = 0; bad = 0;
        rst = 1'b1; push = 1'b0; pop = 1'b0; data_push = 32'h0;
        m_valid = 1'b0; m_data = 32'h0; m_ovf = 1'b0; m_unf = 1'b0;
        test_reset();
        test_fill();
        test_drain();
        test_simultaneous();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
